// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_pkg;

    localparam logic [31:0] RESET_INSTR_DEFAULT = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
    } fetch_entry_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_ring.sv
// Ring storage for fetch entries: head/tail/fill pointers, occupancy and
// unfilled-entry count. Entries are allocated at request time and filled in order.
module fetch_ring
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = ptr_width(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic [31:0]  push_pc,
    input  logic         fill,
    input  logic [31:0]  fill_data,
    input  logic         pop,
    output fetch_entry_t head_entry,
    output logic         fill_at_head,
    output logic [CW-1:0] occ,
    output logic [CW-1:0] unfilled
);

    fetch_entry_t   entries_reg [DEPTH];
    logic [PW-1:0]  head_reg;
    logic [PW-1:0]  tail_reg;
    logic [PW-1:0]  fill_ptr_reg;
    logic [CW-1:0]  occ_reg;
    logic [CW-1:0]  unf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_reg[i] <= '0;
            end
            head_reg     <= '0;
            tail_reg     <= '0;
            fill_ptr_reg <= '0;
            occ_reg      <= '0;
            unf_reg      <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_reg[i].filled <= 1'b0;
            end
            head_reg     <= '0;
            tail_reg     <= '0;
            fill_ptr_reg <= '0;
            occ_reg      <= '0;
            unf_reg      <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && tail_reg == PW'(i)) begin
                    entries_reg[i].pc     <= push_pc;
                    entries_reg[i].filled <= 1'b0;
                end
                if (fill && fill_ptr_reg == PW'(i)) begin
                    entries_reg[i].instr  <= fill_data;
                    entries_reg[i].filled <= 1'b1;
                end
                // A bypassed entry popped in its fill cycle is retired unfilled.
                if (pop && head_reg == PW'(i)) begin
                    entries_reg[i].filled <= 1'b0;
                end
            end
            if (push) tail_reg     <= tail_reg + PW'(1);
            if (fill) fill_ptr_reg <= fill_ptr_reg + PW'(1);
            if (pop)  head_reg     <= head_reg + PW'(1);
            occ_reg <= occ_reg + CW'(push) - CW'(pop);
            unf_reg <= unf_reg + CW'(push) - CW'(fill);
        end
    end

    assign head_entry   = entries_reg[head_reg];
    assign fill_at_head = (fill_ptr_reg == head_reg) && (unf_reg != '0);
    assign occ          = occ_reg;
    assign unfilled     = unf_reg;

endmodule

// File: rtl/fetch_buffer.sv
// IF-stage fetch buffer: request/grant fetch, in-order responses, redirect discard.
// Optional FETCH_BUFFER_BYPASS_EN presents a response at the head in its arrival cycle.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int          DEPTH       = 4,
    parameter logic [31:0] RESET_INSTR = RESET_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        StallF,
    input  logic        StallD,
    output logic        ValidD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D
);

    localparam int            PW      = ptr_width(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    fetch_entry_t  head_entry;
    logic          fill_at_head;
    logic [CW-1:0] occ;
    logic [CW-1:0] unfilled;
    logic [CW-1:0] discard_reg;
    logic [CW-1:0] discard_next;
    logic [CW:0]   outstanding;
    logic          grant;
    logic          fill;
    logic          pop;
    logic          stored_valid;
    logic [31:0]   pcd_hold_reg;
    logic [31:0]   pc_d;

    // Everything the memory still owes us, live or stale.
    assign outstanding = {1'b0, unfilled} + {1'b0, discard_reg};

    assign imem_req  = !rst && !flush && ({1'b0, occ} < DEPTH_W) && (outstanding < DEPTH_W);
    assign imem_addr = PCF;
    assign grant     = imem_req && imem_gnt;
    assign StallF    = rst || (!flush && !grant);

    assign fill         = imem_rvalid && !flush && (discard_reg == '0) && (unfilled != '0);
    assign stored_valid = head_entry.filled && (occ != '0) && !flush;

`ifdef FETCH_BUFFER_BYPASS_EN
    logic bypass_valid;
    assign bypass_valid = fill && fill_at_head;
    assign ValidD = stored_valid || bypass_valid;
    assign InstrD = stored_valid ? head_entry.instr :
                    bypass_valid ? imem_rdata : RESET_INSTR;
`else
    logic unused_fill_at_head;
    assign unused_fill_at_head = fill_at_head;
    assign ValidD = stored_valid;
    assign InstrD = stored_valid ? head_entry.instr : RESET_INSTR;
`endif

    assign pop      = ValidD && !StallD;
    assign pc_d     = ValidD ? head_entry.pc : pcd_hold_reg;
    assign PCD      = pc_d;
    assign PCPlus4D = pc_d + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pcd_hold_reg <= '0;
        else     pcd_hold_reg <= pc_d;
    end

    // On redirect every outstanding response becomes stale; one arriving now is dropped now.
    always_comb begin
        discard_next = discard_reg;
        if (flush) begin
            if (imem_rvalid && outstanding != '0)
                discard_next = CW'(outstanding - {{CW{1'b0}}, 1'b1});
            else
                discard_next = CW'(outstanding);
        end else if (imem_rvalid && discard_reg != '0) begin
            discard_next = discard_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) discard_reg <= '0;
        else     discard_reg <= discard_next;
    end

    fetch_ring #(.DEPTH(DEPTH)) u_ring (
        .clk          (clk),
        .rst          (rst),
        .clear        (flush),
        .push         (grant),
        .push_pc      (PCF),
        .fill         (fill),
        .fill_data    (imem_rdata),
        .pop          (pop),
        .head_entry   (head_entry),
        .fill_at_head (fill_at_head),
        .occ          (occ),
        .unfilled     (unfilled)
    );

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: queue-based reference model plus in-order memory responder.
// Expectations adapt to FETCH_BUFFER_BYPASS_EN when that macro is defined.
module tb_fetch_buffer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FETCH_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        StallF;
    logic        StallD;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .PCF         (PCF),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .StallF      (StallF),
        .StallD      (StallD),
        .ValidD      (ValidD),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the buffer as a queue of outstanding fetches.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          filled;
    } ment_t;
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    ment_t       mq[$];
    pend_t       pend[$];
    int          discard  = 0;
    logic [31:0] last_pcd = 32'h0;
    int          last_due = -1;
    int          lat      = 1;
    int          cyc      = 0;
    logic [31:0] target   = 32'h0;

    logic        s_valid, s_req, s_stallf;
    logic [31:0] s_instr, s_pcd, s_pcp4, s_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h200) ? 32'h0050_0093 : (a ^ 32'h1000_0013);
    endfunction

    task automatic cycle();
        int          unf, idx, due, d;
        bit          e_req, e_grant, e_stallf, e_valid, e_pop, live;
        logic [31:0] e_instr, e_pcd, pcf_next;
        @(negedge clk);
        unf = 0;
        idx = -1;
        foreach (mq[i]) begin
            if (!mq[i].filled) begin
                unf++;
                if (idx < 0) idx = i;
            end
        end
        e_req    = !flush && (mq.size() < DEPTH) && ((unf + discard) < DEPTH);
        e_grant  = e_req && imem_gnt;
        e_stallf = !flush && !e_grant;
        live     = imem_rvalid && !flush && (discard == 0) && (unf > 0);
        e_valid  = !flush && (mq.size() > 0) && (mq[0].filled || (BYP && live && idx == 0));
        e_instr  = !e_valid ? NOP : (mq[0].filled ? mq[0].instr : imem_rdata);
        e_pcd    = e_valid ? mq[0].pc : last_pcd;
        e_pop    = e_valid && !StallD;

        s_valid = ValidD;  s_req  = imem_req;  s_stallf = StallF;
        s_instr = InstrD;  s_pcd  = PCD;       s_pcp4   = PCPlus4D;
        s_addr  = imem_addr;
        check("imem_req", s_req, e_req);
        check("imem_addr", s_addr, PCF);
        check("StallF", s_stallf, e_stallf);
        check("ValidD", s_valid, e_valid);
        check("InstrD", s_instr, e_instr);
        check("PCD", s_pcd, e_pcd);
        check("PCPlus4D", s_pcp4, e_pcd + 32'd4);
        if (s_valid && !StallD)
            $display("[TB] cyc %0d pop pc=%h instr=%h", cyc, s_pcd, s_instr);

        @(posedge clk);
        if (flush) begin
            d = discard + unf;
            if (imem_rvalid && d > 0) d--;
            discard = d;
            mq.delete();
        end else begin
            if (imem_rvalid) begin
                if (discard > 0) discard--;
                else if (unf > 0) begin
                    mq[idx].filled = 1'b1;
                    mq[idx].instr  = imem_rdata;
                end
            end
            if (e_pop) void'(mq.pop_front());
            if (e_grant) mq.push_back('{PCF, 32'h0, 1'b0});
        end
        last_pcd = e_pcd;

        if (imem_rvalid) void'(pend.pop_front());
        if (e_grant) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            pend.push_back('{PCF, due});
            last_due = due;
        end
        pcf_next = PCF;
        if (flush) pcf_next = target;
        else if (e_grant) pcf_next = PCF + 32'd4;
        cyc++;

        #1;
        PCF         = pcf_next;
        imem_rvalid = (pend.size() > 0) && (pend[0].due <= cyc);
        imem_rdata  = imem_rvalid ? mem_word(pend[0].addr) : 32'hDEAD_BEEF;
    endtask

    task automatic drain();
        imem_gnt = 1'b0;
        StallD   = 1'b0;
        for (int k = 0; k < 30 && (mq.size() > 0 || pend.size() > 0); k++) cycle();
        if (mq.size() > 0 || pend.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d outstanding required 0", mq.size() + pend.size());
        end
        cycle();
        check("drain_validd", s_valid, 1'b0);
    endtask

    int          first_valid;
    int          n_valid;
    logic [31:0] addr0;
    logic [31:0] popped[$];

    initial begin
        rst = 1'b1; PCF = 32'h0; flush = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; StallD = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ValidD", ValidD, 1'b0);
        check("rst_InstrD", InstrD, NOP);
        check("rst_PCD", PCD, 32'h0);
        check("rst_PCPlus4D", PCPlus4D, 32'h4);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_StallF", StallF, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Streaming with a 1-cycle memory
        imem_gnt = 1'b1; lat = 1; first_valid = -1; n_valid = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (s_valid) begin
                n_valid++;
                if (first_valid < 0) begin
                    first_valid = k;
                    check("t1_first_instr", s_instr, 32'h1000_0013);
                    check("t1_first_pcd", s_pcd, 32'h0);
                    check("t1_first_pcp4", s_pcp4, 32'h4);
                end
            end
        end
`ifdef FETCH_BUFFER_BYPASS_EN
        check("t1_first_valid_cycle", first_valid, 1);
        check("t1_valid_count", n_valid, 7);
`else
        check("t1_first_valid_cycle", first_valid, 2);
        check("t1_valid_count", n_valid, 6);
`endif

        // Grant withheld: request held, PC frozen
        imem_gnt = 1'b0;
        addr0 = PCF;
        check("t2_addr0", addr0, 32'h20);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t2_stallf_hold", s_stallf, 1'b1);
            check("t2_req_hold", s_req, 1'b1);
            check("t2_addr_stable", s_addr, addr0);
        end
        imem_gnt = 1'b1;
        cycle();
        check("t2_stallf_release", s_stallf, 1'b0);
        check("t2_addr_release", s_addr, 32'h20);

        // Decode back-pressure fills the buffer
        drain();
        flush = 1'b1; target = 32'h0;
        cycle();
        flush = 1'b0;
        StallD = 1'b1; imem_gnt = 1'b1; lat = 1;
        repeat (8) cycle();
        check("t3_full_req", s_req, 1'b0);
        check("t3_full_stallf", s_stallf, 1'b1);
        check("t3_frozen_valid", s_valid, 1'b1);
        check("t3_frozen_pcd", s_pcd, 32'h0);
        StallD = 1'b0; imem_gnt = 1'b0;
        popped.delete();
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (s_valid) popped.push_back(s_pcd);
        end
        check("t3_pop_count", popped.size(), 4);
        for (int k = 0; k < 4 && k < popped.size(); k++)
            check("t3_pop_order", popped[k], 32'(k * 4));

        // Redirect with two slow fetches in flight
        drain();
        lat = 3; imem_gnt = 1'b1;
        repeat (2) cycle();
        imem_gnt = 1'b0; flush = 1'b1; target = 32'h100;
        cycle();
        flush = 1'b0; imem_gnt = 1'b1; lat = 1;
        first_valid = -1;
        for (int j = 0; j < 10 && first_valid < 0; j++) begin
            cycle();
            if (s_valid) begin
                first_valid = j;
                check("t4_target_pcd", s_pcd, 32'h100);
                check("t4_target_instr", s_instr, 32'h1000_0113);
            end
        end
`ifdef FETCH_BUFFER_BYPASS_EN
        check("t4_first_valid_cycle", first_valid, 2);
`else
        check("t4_first_valid_cycle", first_valid, 3);
`endif
        imem_gnt = 1'b0;

        // Redirect coinciding with the only response in flight
        drain();
        lat = 2; imem_gnt = 1'b1;
        cycle();
        imem_gnt = 1'b0;
        cycle();
        flush = 1'b1; target = 32'h200;
        cycle();
        flush = 1'b0; imem_gnt = 1'b1; lat = 1;
        cycle();
        check("t5_empty_after_flush", s_valid, 1'b0);
        check("t5_req_after_flush", s_req, 1'b1);
        imem_gnt = 1'b0;
        cycle();
`ifdef FETCH_BUFFER_BYPASS_EN
        check("t5_bypass_valid", s_valid, 1'b1);
        check("t5_bypass_instr", s_instr, 32'h0050_0093);
        check("t5_bypass_pcd", s_pcd, 32'h200);
        cycle();
        check("t5_after_bypass_valid", s_valid, 1'b0);
`else
        check("t5_same_cycle_valid", s_valid, 1'b0);
        cycle();
        check("t5_next_valid", s_valid, 1'b1);
        check("t5_next_instr", s_instr, 32'h0050_0093);
        check("t5_next_pcd", s_pcd, 32'h200);
`endif
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
